// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: LSB first, with a frame-start pulse on bit 0 and a done pulse after the last bit.
// Optional two's-complement negation of the outgoing stream when SER_TX_NEGATE_EN is defined.
module serial_word_tx #(
  parameter int W = 8
) (
  input  logic         t_clock,
  input  logic         r_n,
  input  logic         load_valid,
  input  logic [W-1:0] load_data,
`ifdef SER_TX_NEGATE_EN
  input  logic         neg,
`endif
  output logic         load_ready,
  output logic         i,
  output logic         r,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  shreg;
  logic          accept;
  logic          nxt_bit;

  assign accept = load_valid && load_ready;

`ifdef SER_TX_NEGATE_EN
  logic neg_q;
  logic seen;

  // Serial two's complement: copy bits through the first 1, invert everything after it.
  function automatic logic negate_bit(input logic b, input logic en, input logic seen_one);
    return b ^ (en & seen_one);
  endfunction

  assign nxt_bit = negate_bit(shreg[0], neg_q, seen);
`else
  assign nxt_bit = shreg[0];
`endif

  // Bit 0 leaves directly from load_data, so the register holds only the bits still to go.
  always_ff @(posedge t_clock) begin
    if (accept) begin
      shreg <= load_data >> 1;
    end else if (state == SHIFT) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) begin
      state      <= IDLE;
      cnt        <= '0;
      i          <= 1'b0;
      r          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b0;
`ifdef SER_TX_NEGATE_EN
      neg_q      <= 1'b0;
      seen       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state      <= SHIFT;
            cnt        <= '0;
            i          <= load_data[0];
            r          <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            load_ready <= 1'b0;
`ifdef SER_TX_NEGATE_EN
            neg_q      <= neg;
            seen       <= load_data[0];
`endif
          end else begin
            state      <= IDLE;
            i          <= 1'b0;
            r          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        SHIFT: begin
          r <= 1'b0;
          // cnt is the index of the bit currently on i; stop after bit W-1 without wrapping.
          if (cnt == CW'(W - 1)) begin
            state      <= DONE;
            i          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            load_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            i   <= nxt_bit;
`ifdef SER_TX_NEGATE_EN
            seen <= seen | shreg[0];
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: stimulus pushes expected serial frames, a negedge monitor pops and compares.
module tb_serial_word_tx;
  localparam int W = 8;

  logic         t_clock = 1'b0;
  logic         r_n = 1'b0;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
`ifdef SER_TX_NEGATE_EN
  logic         neg = 1'b0;
`endif
  logic         load_ready, i, r, busy, done;

  int checks = 0;
  int failures = 0;
  logic [3:0] expq[$];
  logic [3:0] mon_e;
  int waited;

  always #5 t_clock = ~t_clock;

  serial_word_tx #(.W(W)) dut (
    .t_clock    (t_clock),
    .r_n        (r_n),
    .load_valid (load_valid),
    .load_data  (load_data),
`ifdef SER_TX_NEGATE_EN
    .neg        (neg),
`endif
    .load_ready (load_ready),
    .i          (i),
    .r          (r),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Entries are {done, busy, r, i}; every busy or done cycle consumes one.
  always @(negedge t_clock) begin
    if (r_n && (busy || done)) begin
      if (expq.size() == 0) begin
        chk("unexpected_output", {4'b0, done, busy, r, i}, 8'h00);
      end else begin
        mon_e = expq.pop_front();
        chk("stream", {4'b0, done, busy, r, i}, {4'b0, mon_e});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle carrying bit 0.
  task automatic send(input logic [W-1:0] d, input logic [W-1:0] expw, output int n);
    n = 0;
    while (!load_ready && n < 40) begin
      @(posedge t_clock); #1;
      n++;
    end
    if (!load_ready) chk("ready_timeout", {7'b0, load_ready}, 8'h01);
    load_valid = 1'b1;
    load_data  = d;
    for (int j = 0; j < W; j++) expq.push_back({1'b0, 1'b1, (j == 0), expw[j]});
    expq.push_back(4'b1000);
    @(posedge t_clock); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done || expq.size() != 0) && n < 60) begin
      @(posedge t_clock); #1;
      n++;
    end
    chk("idle_reached", {6'b0, busy, done}, 8'h00);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {3'b0, load_ready, i, r, busy, done}, 8'h00);
    @(posedge t_clock); @(posedge t_clock); #1;
    r_n = 1'b1;
    chk("ready_before_first_edge", {7'b0, load_ready}, 8'h00);
    @(posedge t_clock); #1;
    chk("ready_after_release", {7'b0, load_ready}, 8'h01);

    // Single word 0x05
    send(8'h05, 8'h05, waited);
    chk("first_bit_flags", {6'b0, busy, r}, 8'h03);
    wait_idle();
    chk("idle_after_word", {3'b0, load_ready, busy, done, i, r}, 8'h10);

    // Back-to-back 0xA3 then 0x3C accepted in DONE
    send(8'hA3, 8'hA3, waited);
    send(8'h3C, 8'h3C, waited);
    chk("ready_wait_cycles", 8'(waited), 8'd8);
    chk("no_gap_bit0", {6'b0, busy, r}, 8'h03);
    wait_idle();

    // load_valid held during SHIFT with changing data
    send(8'h5A, 8'h5A, waited);
    for (int k = 0; k < W - 1; k++) begin
      load_valid = 1'b1;
      load_data  = 8'(k * 37 + 1);
      chk("ready_low_in_shift", {7'b0, load_ready}, 8'h00);
      @(posedge t_clock); #1;
    end
    load_valid = 1'b0;
    wait_idle();

    // Reset in the middle of 0xFF at bit 4
    send(8'hFF, 8'hFF, waited);
    repeat (4) begin
      @(posedge t_clock); #1;
    end
    chk("bit4_before_reset", {6'b0, busy, i}, 8'h03);
    #1 r_n = 1'b0;
    #1;
    chk("async_reset", {3'b0, i, r, busy, done, load_ready}, 8'h00);
    expq.delete();
    @(posedge t_clock); @(posedge t_clock); #1;
    r_n = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h55;
    chk("ready_low_at_release", {7'b0, load_ready}, 8'h00);
    @(posedge t_clock); #1;
    load_valid = 1'b0;
    chk("valid_at_release_ignored", {6'b0, load_ready, busy}, 8'h02);
    repeat (3) begin
      @(posedge t_clock); #1;
    end
    chk("stays_idle", {5'b0, busy, done, i}, 8'h00);

`ifdef SER_TX_NEGATE_EN
    neg = 1'b1;
    send(8'h06, 8'hFA, waited);
    wait_idle();
    send(8'h80, 8'h80, waited);
    wait_idle();
    send(8'h00, 8'h00, waited);
    wait_idle();
    neg = 1'b0;
    send(8'h06, 8'h06, waited);
    wait_idle();
`endif

    wait_idle();
    chk("queue_drained", 8'(expq.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
SERIAL_WORD_TX -- requirements
Module: serial_word_tx

Interface
REQ-001 SHALL have parameter W, default 8, meaning word width in bits (W >= 2).
REQ-002 SHALL have port t_clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port r_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load_valid  input  1  producer offers load_data this cycle.
REQ-005 SHALL have port load_data  input  W  parallel word to transmit.
REQ-006 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port i  output  1  serial data bit, LSB first; pin-compatible with the serial converter's i input.
REQ-008 SHALL have port r  output  1  frame-start pulse, high during bit 0 only; pin-compatible with the converter's r input.
REQ-009 SHALL have port busy  output  1  high while a word is being shifted out.
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last bit.
REQ-011 SHALL have port neg  input  1  negate request, sampled with load; present only when SER_TX_NEGATE_EN is defined.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL assert load_ready in IDLE and DONE and deassert it in SHIFT.
REQ-014 SHALL accept a word on the edge where load_valid && load_ready, capturing load_data into a W-bit shift register and clearing the bit counter.
REQ-015 SHALL ignore load_valid when load_ready is low, with no capture and no state change.
REQ-016 SHALL go from IDLE or DONE to SHIFT on acceptance; DONE without acceptance SHALL return to IDLE.
REQ-017 SHALL present bit j of the accepted word on i (registered) in the (j+1)th cycle after acceptance, for j = 0..W-1.
REQ-018 SHALL drive r=1 only in the cycle carrying bit 0, and r=0 otherwise.
REQ-019 SHALL hold busy=1 in every SHIFT cycle and busy=0 in IDLE and DONE.
REQ-020 SHALL use a bit counter of width clog2(W), incrementing once per SHIFT cycle, and move SHIFT->DONE after bit W-1 with no wrap-around past W-1.
REQ-021 SHALL drive done=1, i=0 and r=0 for exactly the one DONE cycle.
REQ-022 SHALL support back-to-back words: acceptance in DONE puts bit 0 of the next word on the cycle after DONE, so each word occupies W+1 cycles.
REQ-023 SHALL drive i=0 and r=0 in IDLE.

Reset
REQ-024 SHALL, while r_n=0, immediately force state IDLE, i=0, r=0, busy=0, done=0 and load_ready=0, regardless of the clock.
REQ-025 SHALL assert load_ready=1 on the first cycle after r_n rises.
REQ-026 SHALL discard any partially sent word when reset is asserted mid-operation, with no done pulse for it.

Configuration
REQ-027 SHALL, when macro SER_TX_NEGATE_EN is defined, add port neg, sampled at acceptance; with neg=1 the serial stream SHALL be the two's complement of the word (bits up to and including the first 1 copied, later bits inverted, "seen-one" flag cleared at acceptance), giving (-load_data) mod 2^W.
REQ-028 SHALL, when SER_TX_NEGATE_EN is undefined, omit the neg port and the seen-one flag and always transmit load_data unmodified.

Verification
REQ-029 SHALL cover: W=8, reset released, load 0x05 -> i over 8 cycles = 1,0,1,0,0,0,0,0, r=1 on the first cycle only, done=1 on cycle 9, then IDLE.
REQ-030 SHALL cover: load 0xA3 then 0x3C accepted during DONE -> 16 data cycles plus 2 done pulses, r pulsing at bit 0 of each word, no idle gap.
REQ-031 SHALL cover: load_valid held high during SHIFT with changing load_data -> load_ready=0 and the stream is unaffected.
REQ-032 SHALL cover: r_n dropped at bit 4 of 0xFF -> i, r, busy and done go to 0 immediately, no done pulse, and load_ready=1 the cycle after release.
REQ-033 SHALL cover, with SER_TX_NEGATE_EN: 0x06 neg=1 -> 0,1,0,1,1,1,1,1 (0xFA); 0x80 neg=1 -> 0x80; 0x00 neg=1 -> 0x00; 0x06 neg=0 -> 0x06.
REQ-034 SHALL cover: load_valid asserted in the same cycle r_n rises -> not accepted, since load_ready is still 0.
